// File: rtl/reu_pkg.sv
// REU DMA sequencer shared types.
// Transfer type encodings and sequencer states.
package reu_pkg;

  typedef enum logic [1:0] {
    TT_STASH  = 2'b00,
    TT_FETCH  = 2'b01,
    TT_RSVD   = 2'b10,
    TT_VERIFY = 2'b11
  } ttype_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } seq_e;

endpackage

// File: rtl/reu_phi2_edge.sv
// PHI2 synchroniser for the C8M domain.
// Two sync flops plus one history flop give rise/fall strobes.
module reu_phi2_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  // shift PHI2 through sync and history stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], phi2};
  end

  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: steps C64/REU/length counters per PHI2
// and issues SDRAM commands plus C64 bus controls.
module reu_dma_seq
  import reu_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic        C8M,
  input  logic        nRESET,
  input  logic        PHI2,
  input  logic        GO,
  input  logic [1:0]  TTYPE,
  input  logic        AUTOLOAD,
  input  logic        FIXC64,
  input  logic        FIXREU,
  input  logic [15:0] C64BASE,
  input  logic [23:0] REUBASE,
  input  logic [15:0] LENBASE,
  input  logic        BA,
  input  logic [7:0]  D64,
  input  logic [7:0]  RDD,
  output logic        RDCMD,
  output logic        WRCMD,
  output logic [23:0] A,
  output logic [15:0] C64A,
  output logic        C64WE,
  output logic        nDMA,
  output logic        BUSY,
  output logic        DONE,
  output logic        VERR,
  output logic [15:0] CURC64,
  output logic [23:0] CURREU,
  output logic [15:0] CURLEN
);

  localparam logic [AW-1:0] REU_ONE = AW'(1);

  seq_e          state, nstate;
  ttype_e        tt, tt_in;
  logic          rise, fall;
  logic          pend, start, vchk, mism, act, last;
  logic          autold, fixc, fixr;
  logic [15:0]   c64c, lenc;
  logic [AW-1:0] reuc;
  logic          n_rd, n_wr, n_we, n_ndma, n_busy;
  logic [23:0]   n_a;
  logic [15:0]   n_c64a;

  reu_phi2_edge u_edge (
    .clk   (C8M),
    .rst_n (nRESET),
    .phi2  (PHI2),
    .rise  (rise),
    .fall  (fall)
  );

  assign tt_in = ttype_e'(TTYPE);
  assign start = pend | GO;
  assign act   = (state == ST_XFER) && BA;
  assign last  = (lenc == 16'd1);
  assign mism  = fall && vchk && (D64 != RDD);

  assign CURC64 = c64c;
  assign CURREU = 24'(reuc);
  assign CURLEN = lenc;

  // state register
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= nstate;
  end

  // next-state: PHI2-rise stepping, verify abort on PHI2 fall
  always_comb begin
    nstate = state;
    if (mism) begin
      nstate = ST_DONE;
    end else if (rise) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            unique case (1'b1)
              tt_in == TT_STASH: nstate = ST_XFER;
              tt_in == TT_RSVD:  nstate = ST_DONE;
              default:           nstate = ST_PRIME;
            endcase
          end
        end
        ST_PRIME: nstate = ST_XFER;
        ST_XFER: begin
          if (BA && last)
            nstate = (tt == TT_STASH) ? ST_DRAIN : ST_DONE;
        end
        ST_DRAIN: nstate = ST_DONE;
        ST_DONE:  nstate = ST_IDLE;
        default:  nstate = ST_IDLE;
      endcase
    end
  end

  // output values to be latched at the next PHI2 rise
  always_comb begin
    n_rd   = 1'b0;
    n_wr   = 1'b0;
    n_we   = 1'b0;
    n_a    = A;
    n_c64a = C64A;
    n_ndma = nDMA;
    n_busy = BUSY;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          n_ndma = 1'b0;
          n_busy = 1'b1;
        end
      end
      ST_PRIME: begin
        n_rd = 1'b1;
        n_a  = 24'(reuc);
      end
      ST_XFER: begin
        if (BA) begin
          n_c64a = c64c;
          if (tt == TT_STASH) begin
            n_wr = 1'b1;
            n_a  = 24'(reuc);
          end else begin
            n_we = (tt == TT_FETCH);
            if (!last) begin
              n_rd = 1'b1;
              n_a  = 24'(reuc);
            end
          end
        end
      end
      ST_DRAIN: n_wr = 1'b1;
      ST_DONE: begin
        n_ndma = 1'b1;
        n_busy = 1'b0;
      end
      default: ;
    endcase
  end

  // registered outputs, DONE pulse and sticky verify error
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      RDCMD <= 1'b0;
      WRCMD <= 1'b0;
      C64WE <= 1'b0;
      A     <= '0;
      C64A  <= '0;
      nDMA  <= 1'b1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      VERR  <= 1'b0;
    end else begin
      DONE <= rise && (state == ST_DONE);
      if (rise) begin
        RDCMD <= n_rd;
        WRCMD <= n_wr;
        C64WE <= n_we;
        A     <= n_a;
        C64A  <= n_c64a;
        nDMA  <= n_ndma;
        BUSY  <= n_busy;
        if (state == ST_IDLE && start) VERR <= 1'b0;
      end else if (mism) begin
        VERR <= 1'b1;
      end
    end
  end

  // start request latch and verify-compare arm flag
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      pend <= 1'b0;
      vchk <= 1'b0;
    end else begin
      if (rise && state == ST_IDLE) pend <= 1'b0;
      else if (GO && state == ST_IDLE) pend <= 1'b1;
      if (rise) vchk <= act && (tt == TT_VERIFY);
      else if (fall) vchk <= 1'b0;
    end
  end

  // address and length counters, options captured at start
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      c64c   <= '0;
      reuc   <= '0;
      lenc   <= '0;
      tt     <= TT_STASH;
      autold <= 1'b0;
      fixc   <= 1'b0;
      fixr   <= 1'b0;
    end else if (rise) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            c64c   <= C64BASE;
            reuc   <= REUBASE[AW-1:0];
            lenc   <= LENBASE;
            tt     <= tt_in;
            autold <= AUTOLOAD;
            fixc   <= FIXC64;
            fixr   <= FIXREU;
          end
        end
        ST_PRIME: begin
          if (!fixr) reuc <= reuc + REU_ONE;
        end
        ST_XFER: begin
          if (BA) begin
            lenc <= lenc - 16'd1;
            if (!fixc) c64c <= c64c + 16'd1;
            if (!fixr && (tt == TT_STASH || !last))
              reuc <= reuc + REU_ONE;
          end
        end
        ST_DONE: begin
          if (autold) begin
            c64c <= C64BASE;
            reuc <= REUBASE[AW-1:0];
            lenc <= LENBASE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed bench for reu_dma_seq: stash, fetch, verify,
// stalls, wrap, reset abort, autoload and reserved type.
module tb_reu_dma_seq;

  logic        C8M, nRESET, PHI2, GO;
  logic [1:0]  TTYPE;
  logic        AUTOLOAD, FIXC64, FIXREU, BA;
  logic [15:0] C64BASE, LENBASE;
  logic [23:0] REUBASE;
  logic [7:0]  D64, RDD;
  logic        RDCMD, WRCMD, C64WE, nDMA, BUSY, DONE, VERR;
  logic [23:0] A, CURREU;
  logic [15:0] C64A, CURC64, CURLEN;

  int total = 0;
  int bad = 0;
  int wr_cnt, rd_cnt, done_cnt;
  logic        s_rd, s_wr, s_we, s_ndma, s_busy, s_done;
  logic [23:0] s_a;
  logic [15:0] s_c64a;
  logic        prev_wr;
  logic [23:0] prev_a;

  reu_dma_seq #(.AW(24)) dut (
    .C8M(C8M), .nRESET(nRESET), .PHI2(PHI2), .GO(GO),
    .TTYPE(TTYPE), .AUTOLOAD(AUTOLOAD), .FIXC64(FIXC64),
    .FIXREU(FIXREU), .C64BASE(C64BASE), .REUBASE(REUBASE),
    .LENBASE(LENBASE), .BA(BA), .D64(D64), .RDD(RDD),
    .RDCMD(RDCMD), .WRCMD(WRCMD), .A(A), .C64A(C64A),
    .C64WE(C64WE), .nDMA(nDMA), .BUSY(BUSY), .DONE(DONE),
    .VERR(VERR), .CURC64(CURC64), .CURREU(CURREU),
    .CURLEN(CURLEN)
  );

  initial C8M = 1'b0;
  always #5 C8M = ~C8M;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half(input logic lvl);
    PHI2 = lvl;
    for (int i = 0; i < 4; i++) begin
      @(negedge C8M);
      if (DONE) begin
        s_done = 1'b1;
        done_cnt++;
      end
    end
  endtask

  // one PHI2 cycle; samples rise-updated outputs before the fall
  task automatic cyc();
    s_done = 1'b0;
    half(1'b1);
    s_rd   = RDCMD;
    s_wr   = WRCMD;
    s_we   = C64WE;
    s_a    = A;
    s_c64a = C64A;
    s_ndma = nDMA;
    s_busy = BUSY;
    if (WRCMD && !(prev_wr && A == prev_a)) wr_cnt++;
    prev_wr = WRCMD;
    prev_a  = A;
    if (RDCMD) rd_cnt++;
    half(1'b0);
  endtask

  task automatic go();
    @(negedge C8M);
    GO = 1'b1;
    @(negedge C8M);
    GO = 1'b0;
  endtask

  task automatic clr();
    wr_cnt  = 0;
    rd_cnt  = 0;
    prev_wr = 1'b0;
    prev_a  = '0;
  endtask

  initial begin
    nRESET = 1'b0; PHI2 = 1'b0; GO = 1'b0; TTYPE = 2'b00;
    AUTOLOAD = 1'b0; FIXC64 = 1'b0; FIXREU = 1'b0; BA = 1'b1;
    C64BASE = '0; REUBASE = '0; LENBASE = '0;
    D64 = 8'h00; RDD = 8'h00;
    done_cnt = 0;
    clr();
    repeat (3) @(negedge C8M);
    chk("rst_busy", BUSY, 0);
    chk("rst_ndma", nDMA, 1);
    chk("rst_cmd", {RDCMD, WRCMD, C64WE}, 0);
    chk("rst_a", A, 0);
    chk("rst_done_verr", {DONE, VERR}, 0);
    chk("rst_len", CURLEN, 0);
    nRESET = 1'b1;
    repeat (2) @(negedge C8M);

    // stash 3 bytes, with a GO pulse while busy
    TTYPE = 2'b00; C64BASE = 16'h1000; REUBASE = 24'h000020;
    LENBASE = 16'd3;
    clr();
    go();
    cyc();
    chk("st_start_busy", s_busy, 1);
    chk("st_start_ndma", s_ndma, 0);
    chk("st_start_wr", s_wr, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_c64a", s_c64a, 32'h1000 + i);
      chk("st_a", s_a, 32'h20 + i);
      chk("st_wr_we", {s_wr, s_we}, 2'b10);
      if (i == 0) go();
    end
    cyc();
    chk("st_drain", {s_wr, s_we, s_a}, {2'b10, 24'h000022});
    cyc();
    chk("st_done", s_done, 1);
    chk("st_end_bus", {s_busy, s_ndma, s_wr}, 3'b010);
    chk("st_len", CURLEN, 0);
    chk("st_c64", CURC64, 16'h1003);
    chk("st_reu", CURREU, 24'h000023);
    chk("st_wrcnt", wr_cnt, 3);
    cyc();
    chk("st_go_ignored", s_busy, 0);
    chk("st_done_cnt", done_cnt, 1);

    // fetch 2 bytes to a fixed C64 address
    TTYPE = 2'b01; FIXC64 = 1'b1; C64BASE = 16'hD020;
    REUBASE = 24'h000100; LENBASE = 16'd2;
    clr();
    go();
    cyc();
    cyc();
    chk("fe_prime", {s_rd, s_we, s_a}, {2'b10, 24'h000100});
    cyc();
    chk("fe_b1", {s_we, s_c64a, s_rd, s_a},
        {1'b1, 16'hD020, 1'b1, 24'h000101});
    cyc();
    chk("fe_b2", {s_we, s_c64a, s_rd}, {1'b1, 16'hD020, 1'b0});
    cyc();
    chk("fe_done", {s_done, s_we, s_rd}, 3'b100);
    chk("fe_rdcnt", rd_cnt, 2);
    chk("fe_c64", CURC64, 16'hD020);
    chk("fe_reu", CURREU, 24'h000102);
    FIXC64 = 1'b0;

    // verify 4 bytes, mismatch on byte 2
    TTYPE = 2'b11; C64BASE = 16'h3000; REUBASE = 24'h000200;
    LENBASE = 16'd4; D64 = 8'h55; RDD = 8'h55;
    clr();
    go();
    cyc();
    cyc();
    cyc();
    chk("vf_b1_ok", {s_we, VERR}, 2'b00);
    D64 = 8'hAA;
    cyc();
    chk("vf_b2_err", VERR, 1);
    cyc();
    chk("vf_done", {s_done, s_rd, s_busy, s_ndma}, 4'b1001);
    chk("vf_len", CURLEN, 2);
    chk("vf_c64", CURC64, 16'h3002);
    chk("vf_rdcnt", rd_cnt, 3);
    clr();
    cyc();
    cyc();
    chk("vf_quiet", rd_cnt + wr_cnt, 0);
    chk("vf_sticky", VERR, 1);
    chk("vf_done_cnt", done_cnt, 3);

    // stash 4 bytes with a 3-cycle BA stall after byte 1
    TTYPE = 2'b00; C64BASE = 16'h2000; REUBASE = 24'h000040;
    LENBASE = 16'd4;
    clr();
    go();
    cyc();
    chk("sl_verr_clr", VERR, 0);
    cyc();
    chk("sl_b1", {s_c64a, s_a}, {16'h2000, 24'h000040});
    BA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sl_stall_cmd", {s_wr, s_rd, s_we, s_ndma}, 0);
      chk("sl_stall_cnt", {CURC64, CURLEN}, {16'h2001, 16'd3});
    end
    BA = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("sl_b", {s_wr, s_c64a, s_a},
          {1'b1, 16'h2000 + 16'(i), 24'h000040 + 24'(i)});
    end
    cyc();
    cyc();
    chk("sl_done", s_done, 1);
    chk("sl_wrcnt", wr_cnt, 4);

    // 65536-byte stash: wrap then reset abort
    C64BASE = 16'hFFFE; REUBASE = 24'hFFFFFF; LENBASE = 16'd0;
    AUTOLOAD = 1'b1;
    clr();
    go();
    cyc();
    cyc();
    chk("wr_b1", {s_a, s_c64a}, {24'hFFFFFF, 16'hFFFE});
    cyc();
    chk("wr_b2", {s_a, s_c64a}, {24'h000000, 16'hFFFF});
    cyc();
    chk("wr_b3", {s_a, s_c64a}, {24'h000001, 16'h0000});
    chk("wr_len", CURLEN, 16'hFFFD);
    chk("wr_busy", BUSY, 1);
    @(negedge C8M);
    nRESET = 1'b0;
    #1;
    chk("ab_bus", {BUSY, nDMA, WRCMD, RDCMD, C64WE}, 5'b01000);
    chk("ab_a", {A, C64A}, 0);
    chk("ab_cnt", {CURREU, CURC64, CURLEN}, 0);
    repeat (3) @(negedge C8M);
    nRESET = 1'b1;
    cyc();
    cyc();
    chk("ab_no_done", done_cnt, 4);
    chk("ab_idle", s_busy, 0);

    // short autoload stash crossing the REU wrap
    C64BASE = 16'h0010; REUBASE = 24'hFFFFFF; LENBASE = 16'd2;
    clr();
    go();
    cyc();
    cyc();
    chk("al_b1", s_a, 24'hFFFFFF);
    cyc();
    chk("al_b2", s_a, 24'h000000);
    cyc();
    cyc();
    chk("al_done", s_done, 1);
    chk("al_reload", {CURREU, CURC64, CURLEN},
        {24'hFFFFFF, 16'h0010, 16'd2});

    // reserved type finishes with no accesses
    TTYPE = 2'b10; AUTOLOAD = 1'b0;
    clr();
    go();
    cyc();
    chk("rs_busy", s_busy, 1);
    cyc();
    chk("rs_done", s_done, 1);
    chk("rs_noacc", rd_cnt + wr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
